// File: rtl/store_pack_unit_pkg.sv
// Store packing unit shared definitions: store opcodes,
// byte-enable constants and the queued entry layout.
package store_pack_unit_pkg;

   typedef enum logic [1:0] {
      ST_SW  = 2'b00,
      ST_SH  = 2'b01,
      ST_SB  = 2'b10,
      ST_RSV = 2'b11
   } st_op_e;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_NONE    = 4'b0000;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } st_entry_t;

   localparam int ENTRY_W = $bits(st_entry_t);

endpackage

// File: rtl/store_fifo.sv
// In-order store queue: circular storage, wrapping pointers
// and an occupancy counter spanning 0..DEPTH.
module store_fifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             din_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             dout_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;

   // DEPTH is a power of two, so pointer overflow is the wrap.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q + CW'(push_i) - CW'(pop_i);
      if (push_i) wptr_d = wptr_q + PW'(1);
      if (pop_i)  rptr_d = rptr_q + PW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/store_pack_unit.sv
// Store packing unit: lane-places sw/sh/sb data into queued word writes.
// Define ALIGN_CHECK_EN to trap misaligned and reserved stores.
module store_pack_unit
   import store_pack_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [1:0]  st_op,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   output logic        err_valid,
   output logic [31:0] err_addr
);

   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   st_entry_t     ent;
   st_entry_t     head;
   logic [CW-1:0] count;
   logic          accept;
   logic          drop;
   logic          fault;
   logic          push;
   logic          pop;

   assign st_ready = (count < DEPTH_C);
   assign accept   = st_valid && st_ready;

   always_comb begin
      ent      = '0;
      ent.addr = {st_addr[31:2], 2'b00};
      drop     = 1'b0;
      fault    = 1'b0;
      unique case (st_op)
         ST_SW: begin
            ent.wdata = st_data;
            ent.be    = BE_WORD;
`ifdef ALIGN_CHECK_EN
            fault     = (st_addr[1:0] != 2'b00);
`endif
         end
         ST_SH: begin
            ent.wdata = {2{st_data[15:0]}};
            ent.be    = st_addr[1] ? BE_HALF_HI : BE_HALF_LO;
`ifdef ALIGN_CHECK_EN
            fault     = st_addr[0];
`endif
         end
         ST_SB: begin
            ent.wdata = {4{st_data[7:0]}};
            ent.be    = 4'b0001 << st_addr[1:0];
         end
         default: begin
            drop      = 1'b1;
`ifdef ALIGN_CHECK_EN
            fault     = 1'b1;
`endif
         end
      endcase
   end

   assign push = accept && !drop && !fault;
   assign pop  = mem_valid && mem_ready;

   store_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (ent),
      .pop_i   (pop),
      .dout_o  (head),
      .count_o (count)
   );

   assign mem_valid = (count != '0);
   assign mem_addr  = head.addr;
   assign mem_wdata = head.wdata;
   assign mem_be    = mem_valid ? head.be : BE_NONE;

`ifdef ALIGN_CHECK_EN
   logic        err_valid_q, err_valid_d;
   logic [31:0] err_addr_q, err_addr_d;

   always_comb begin
      err_valid_d = accept && fault;
      err_addr_d  = err_addr_q;
      if (accept && fault) err_addr_d = st_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         err_valid_q <= err_valid_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign err_valid = err_valid_q;
   assign err_addr  = err_addr_q;
`else
   assign err_valid = 1'b0;
   assign err_addr  = '0;
`endif

endmodule

// File: tb/tb_store_pack_unit.sv
// Directed and random checks of store_pack_unit against a
// queue-based reference model of store packing.
module tb_store_pack_unit;

   localparam int DEPTH = 2;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [1:0]  st_op = 2'b00;
   logic [31:0] st_addr = '0;
   logic [31:0] st_data = '0;
   logic        mem_valid;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        err_valid;
   logic [31:0] err_addr;

   int tests = 0;
   int fails = 0;

   ent_t        q[$];
   logic        exp_err_v = 1'b0;
   logic [31:0] exp_err_a = '0;

   store_pack_unit #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_op     (st_op),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .err_valid (err_valid),
      .err_addr  (err_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference packing: pick the lanes the store covers and
   // replicate the operand across every lane.
   function automatic ent_t pack(input logic [1:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] d);
      ent_t e;
      int   lane;
      e.a = a - (a % 4);
      lane = int'(a % 4);
      case (op)
         2'd0: begin
            e.d  = d;
            e.be = 4'hF;
         end
         2'd1: begin
            lane = (lane / 2) * 2;
            e.d  = (d & 32'hFFFF) * 32'h0001_0001;
            e.be = 4'(3 << lane);
         end
         default: begin
            e.d  = (d & 32'hFF) * 32'h0101_0101;
            e.be = 4'(1 << lane);
         end
      endcase
      return e;
   endfunction

   function automatic bit is_fault(input logic [1:0] op,
                                   input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
      return (op == 2'd3) || (op == 2'd1 && (a % 2) != 0) ||
             (op == 2'd0 && (a % 4) != 0);
`else
      return (op == 2'd3) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   task automatic check_outputs();
      chk("st_ready", 32'(st_ready), 32'(q.size() < DEPTH));
      chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("mem_addr", mem_addr, q[0].a);
         chk("mem_wdata", mem_wdata, q[0].d);
         chk("mem_be", 32'(mem_be), 32'(q[0].be));
      end else begin
         chk("mem_be_idle", 32'(mem_be), 32'h0);
      end
      chk("err_valid", 32'(err_valid), 32'(exp_err_v));
      chk("err_addr", err_addr, exp_err_a);
   endtask

   task automatic step(input logic v, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic mr);
      bit   acc;
      bit   pop;
      bit   flt;
      ent_t tmp;
      st_valid  = v;
      st_op     = op;
      st_addr   = a;
      st_data   = d;
      mem_ready = mr;
      #1;
      check_outputs();
      acc = v && (q.size() < DEPTH);
      pop = (q.size() != 0) && mr;
      flt = is_fault(op, a);
      @(posedge clk);
      #1;
      if (pop) tmp = q.pop_front();
      if (acc && !flt && op != 2'd3) q.push_back(pack(op, a, d));
      exp_err_v = acc && flt;
      if (acc && flt) exp_err_a = a;
   endtask

   initial begin
      #2;
      chk("rst_mem_valid", 32'(mem_valid), 32'h0);
      chk("rst_mem_be", 32'(mem_be), 32'h0);
      chk("rst_st_ready", 32'(st_ready), 32'h1);
      chk("rst_err_valid", 32'(err_valid), 32'h0);
      chk("rst_err_addr", err_addr, 32'h0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // sb to the top byte lane
      step(1, 2'b10, 32'h0000_1003, 32'h0000_00AB, 1);
      chk("sb_be", 32'(mem_be), 32'h8);
      chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      chk("sb_addr", mem_addr, 32'h0000_1000);
      step(0, 2'b00, 0, 0, 1);

      // back-pressure: sh then sw, head held while memory stalls
      step(1, 2'b01, 32'h0000_2002, 32'h0000_1234, 0);
      step(1, 2'b00, 32'h0000_2004, 32'hDEAD_BEEF, 0);
      for (int i = 0; i < 3; i++)
         step(1, 2'b10, 32'h0000_2008, 32'h0000_0055, 0);
      chk("stall_be", 32'(mem_be), 32'hC);
      chk("stall_wdata", mem_wdata, 32'h1234_1234);

      // full with pop and push offered together
      step(1, 2'b10, 32'h0000_4001, 32'h0000_0077, 1);
      step(1, 2'b10, 32'h0000_4001, 32'h0000_0077, 1);
      for (int i = 0; i < 4; i++) step(0, 2'b00, 0, 0, 1);

      // misaligned word and reserved op
      step(1, 2'b00, 32'h0000_3001, 32'h1111_2222, 1);
      step(0, 2'b00, 0, 0, 1);
      step(1, 2'b11, 32'h0000_5000, 32'h3333_4444, 1);
      step(0, 2'b00, 0, 0, 1);
      step(1, 2'b01, 32'h0000_6003, 32'h0000_BEEF, 1);
      step(0, 2'b00, 0, 0, 1);

      // reset with two stores pending
      step(1, 2'b00, 32'h0000_7000, 32'hAAAA_AAAA, 0);
      step(1, 2'b00, 32'h0000_7004, 32'hBBBB_BBBB, 0);
      chk("pre_rst_valid", 32'(mem_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(mem_valid), 32'h0);
      chk("async_rst_be", 32'(mem_be), 32'h0);
      chk("async_rst_ready", 32'(st_ready), 32'h1);
      q.delete();
      exp_err_v = 1'b0;
      exp_err_a = '0;
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 2'b00, 0, 0, 1);

      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)),
              $urandom(), $urandom(),
              1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < DEPTH + 2; i++) step(0, 2'b00, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/store_pack_unit.md
STORE_PACK_UNIT -- requirements
Module: store_pack_unit

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, meaning store-queue entries (power of two, >=2).
REQ-002 The module SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 The module SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 The module SHALL have port st_valid  in  1  core presents a store.
REQ-005 The module SHALL have port st_ready  out  1  unit can accept a store.
REQ-006 The module SHALL have port st_op  in  2  store width: 00 sw, 01 sh, 10 sb, 11 reserved.
REQ-007 The module SHALL have port st_addr  in  32  byte address.
REQ-008 The module SHALL have port st_data  in  32  register data, operand in low bits.
REQ-009 The module SHALL have port mem_valid  out  1  queue head valid toward data memory.
REQ-010 The module SHALL have port mem_ready  in  1  memory accepts head.
REQ-011 The module SHALL have port mem_addr  out  32  word address, bits [1:0] = 00.
REQ-012 The module SHALL have port mem_wdata  out  32  lane-placed write data.
REQ-013 The module SHALL have port mem_be  out  4  byte enables, bit i = byte lane i.
REQ-014 The module SHALL have port err_valid  out  1  one-cycle store-fault pulse.
REQ-015 The module SHALL have port err_addr  out  32  faulting st_addr, held until next fault.

Function
REQ-016 A store SHALL be accepted on a rising edge with st_valid && st_ready.
REQ-017 st_ready SHALL be 1 exactly when occupancy < DEPTH, registered-state only, with no combinational path from mem_ready.
REQ-018 Packing: sw: wdata = data, be = 1111; sh: wdata = {2{data[15:0]}}, be = addr[1] ? 1100 : 0011; sb: wdata = {4{data[7:0]}}, be = 0001 << addr[1:0].
REQ-019 mem_addr SHALL be {st_addr[31:2], 2'b00}.
REQ-020 Accepted stores SHALL be queued in order; earliest mem_valid is the cycle after acceptance (latency 1).
REQ-021 mem_valid SHALL equal (occupancy != 0); head is popped on mem_valid && mem_ready.
REQ-022 While mem_valid && !mem_ready, mem_addr/mem_wdata/mem_be SHALL hold stable.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged and keep order; at full, push is blocked by st_ready = 0 even if a pop occurs.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter spans 0..DEPTH.
REQ-025 st_op = 11 SHALL be consumed when st_ready = 1 and never enqueued.
REQ-026 When no entry is valid, mem_wdata/mem_be SHALL be don't-care, but mem_be SHALL be 0000.

Reset
REQ-027 On rst_n low, queue SHALL empty immediately: mem_valid = 0, mem_be = 0000, st_ready = 1, err_valid = 0, err_addr = 0.
REQ-028 Reset mid-queue SHALL discard all pending stores without issuing them.

Configuration
REQ-029 With ALIGN_CHECK_EN defined: sh with addr[0] = 1, sw with addr[1:0] != 00, or op 11 SHALL be consumed, not enqueued, and raise err_valid for one cycle on the next cycle with err_addr = st_addr.
REQ-030 Without ALIGN_CHECK_EN: err_valid is tied 0; sh ignores addr[0], sw ignores addr[1:0]; op 11 is silently dropped.

Structure
REQ-031 A shared package SHALL hold st_op codes (ST_SW, ST_SH, ST_SB, ST_RSV) and the be constants BE_WORD, BE_HALF_LO, BE_HALF_HI.
REQ-032 Queue storage and pointers SHALL be a sub-module store_fifo (width 68, depth DEPTH); packing logic stays in store_pack_unit.

Verification
REQ-033 sb addr 0x1003, data 0x000000AB, mem_ready = 1 -> next cycle mem_addr 0x1000, be 1000, wdata 0xABABABAB.
REQ-034 sh addr 0x2002 data 0x1234 then sw addr 0x2004 data 0xDEADBEEF, mem_ready = 0 for 5 cycles -> st_ready falls after 2 accepts, head stable (be 1100, wdata 0x12341234), then in-order drain.
REQ-035 Queue full with simultaneous mem_ready = 1 and st_valid = 1 -> no accept that cycle; accept the next cycle; no loss, no duplication.
REQ-036 ALIGN_CHECK_EN on: sw addr 0x3001 -> no mem_valid, err_valid pulse, err_addr 0x00003001; off: issued as be 1111 at 0x3000.
REQ-037 rst_n low with 2 pending entries -> mem_valid 0 asynchronously; after release neither store appears.
